// File: rtl/adc_sample_conditioner.sv
// Averages frequency/amplitude ADC conversions over 2**AVG_LOG2 samples per channel and
// publishes the averages only when either one moves by more than HYST.
module adc_sample_conditioner #(
   parameter int ADC_BITS = 8,
   parameter int AVG_LOG2 = 2,
   parameter int HYST     = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [ADC_BITS-1:0] freq_sample,
   input  logic                freq_sample_valid,
   input  logic [ADC_BITS-1:0] amp_sample,
   input  logic                amp_sample_valid,
   input  logic                done_ack,
   output logic [ADC_BITS-1:0] sig_frequency,
   output logic [ADC_BITS-1:0] sig_amplitude,
   output logic                frequency_adc_done,
   output logic                amplitude_adc_done,
   output logic                overrun
);

   localparam int ACC_W = ADC_BITS + AVG_LOG2;
   localparam int CNT_W = AVG_LOG2 + 1;
   localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(1 << AVG_LOG2);
   localparam logic [ADC_BITS:0] HYST_V   = (ADC_BITS + 1)'(HYST);

   typedef enum logic [1:0] {ACCUM, COMPARE, HOLD} state_t;

   state_t              state;
   state_t              next_state;
   logic [ACC_W-1:0]    freq_acc;
   logic [ACC_W-1:0]    amp_acc;
   logic [CNT_W-1:0]    freq_cnt;
   logic [CNT_W-1:0]    amp_cnt;
   logic                done;
   logic                first_pub;
   logic                publish;
   logic                clear_win;
   logic                freq_full;
   logic                amp_full;
   logic                freq_take;
   logic                amp_take;
   logic                freq_drop;
   logic                amp_drop;
   logic [ADC_BITS-1:0] avg_freq;
   logic [ADC_BITS-1:0] avg_amp;

   function automatic logic [ADC_BITS:0] abs_diff(input logic [ADC_BITS-1:0] a,
                                                  input logic [ADC_BITS-1:0] b);
      logic signed [ADC_BITS:0] d;
      d = $signed({1'b0, a}) - $signed({1'b0, b});
      if (d < 0) return $unsigned(-d);
      else        return $unsigned(d);
   endfunction

   assign freq_full = (freq_cnt == FULL_CNT);
   assign amp_full  = (amp_cnt == FULL_CNT);
   assign freq_take = (state == ACCUM) && freq_sample_valid && !freq_full;
   assign amp_take  = (state == ACCUM) && amp_sample_valid && !amp_full;
   assign freq_drop = freq_sample_valid && !freq_take;
   assign amp_drop  = amp_sample_valid && !amp_take;
   assign avg_freq  = freq_acc[ACC_W-1:AVG_LOG2];
   assign avg_amp   = amp_acc[ACC_W-1:AVG_LOG2];

   assign frequency_adc_done = done;
   assign amplitude_adc_done = done;

   always_ff @(posedge clk) begin
      if (rst) state <= ACCUM;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      publish    = 1'b0;
      clear_win  = 1'b0;
      case (state)
         ACCUM: begin
            if (freq_full && amp_full) next_state = COMPARE;
         end
         COMPARE: begin
            if (first_pub ||
                (abs_diff(avg_freq, sig_frequency) > HYST_V) ||
                (abs_diff(avg_amp, sig_amplitude) > HYST_V)) begin
               publish    = 1'b1;
               next_state = HOLD;
            end else begin
               clear_win  = 1'b1;
               next_state = ACCUM;
            end
         end
         HOLD: begin
            if (done_ack) begin
               clear_win  = 1'b1;
               next_state = ACCUM;
            end
         end
         default: next_state = ACCUM;
      endcase
   end

   // Window accumulation, publication and the sticky drop flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         freq_acc      <= '0;
         amp_acc       <= '0;
         freq_cnt      <= '0;
         amp_cnt       <= '0;
         sig_frequency <= '0;
         sig_amplitude <= '0;
         done          <= 1'b0;
         first_pub     <= 1'b1;
         overrun       <= 1'b0;
      end else begin
         if (clear_win) begin
            freq_acc <= '0;
            amp_acc  <= '0;
            freq_cnt <= '0;
            amp_cnt  <= '0;
         end else begin
            if (freq_take) begin
               freq_acc <= freq_acc + ACC_W'(freq_sample);
               freq_cnt <= freq_cnt + CNT_W'(1);
            end
            if (amp_take) begin
               amp_acc <= amp_acc + ACC_W'(amp_sample);
               amp_cnt <= amp_cnt + CNT_W'(1);
            end
         end
         if (publish) begin
            sig_frequency <= avg_freq;
            sig_amplitude <= avg_amp;
            done          <= 1'b1;
            first_pub     <= 1'b0;
         end else if ((state == HOLD) && done_ack) begin
            done <= 1'b0;
         end
         if (freq_drop || amp_drop) overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_adc_sample_conditioner.sv
// Directed bench for adc_sample_conditioner: a default instance (AVG_LOG2=2, HYST=1)
// and a wide-window instance (AVG_LOG2=6) for the accumulator extremes.
module tb_adc_sample_conditioner;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] freq_sample = '0;
   logic       freq_sample_valid = 1'b0;
   logic [7:0] amp_sample = '0;
   logic       amp_sample_valid = 1'b0;
   logic       done_ack = 1'b0;
   logic [7:0] sig_frequency;
   logic [7:0] sig_amplitude;
   logic       frequency_adc_done;
   logic       amplitude_adc_done;
   logic       overrun;

   logic [7:0] w_freq_sample = '0;
   logic       w_freq_valid = 1'b0;
   logic [7:0] w_amp_sample = '0;
   logic       w_amp_valid = 1'b0;
   logic       w_done_ack = 1'b0;
   logic [7:0] w_sig_frequency;
   logic [7:0] w_sig_amplitude;
   logic       w_freq_done;
   logic       w_amp_done;
   logic       w_overrun;

   int n_cmp = 0;
   int n_bad = 0;

   adc_sample_conditioner #(.ADC_BITS(8), .AVG_LOG2(2), .HYST(1)) dut (
      .clk                (clk),
      .rst                (rst),
      .freq_sample        (freq_sample),
      .freq_sample_valid  (freq_sample_valid),
      .amp_sample         (amp_sample),
      .amp_sample_valid   (amp_sample_valid),
      .done_ack           (done_ack),
      .sig_frequency      (sig_frequency),
      .sig_amplitude      (sig_amplitude),
      .frequency_adc_done (frequency_adc_done),
      .amplitude_adc_done (amplitude_adc_done),
      .overrun            (overrun)
   );

   adc_sample_conditioner #(.ADC_BITS(8), .AVG_LOG2(6), .HYST(1)) dut_wide (
      .clk                (clk),
      .rst                (rst),
      .freq_sample        (w_freq_sample),
      .freq_sample_valid  (w_freq_valid),
      .amp_sample         (w_amp_sample),
      .amp_sample_valid   (w_amp_valid),
      .done_ack           (w_done_ack),
      .sig_frequency      (w_sig_frequency),
      .sig_amplitude      (w_sig_amplitude),
      .frequency_adc_done (w_freq_done),
      .amplitude_adc_done (w_amp_done),
      .overrun            (w_overrun)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish (observed timeout, required finish)");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One cycle of inputs on the default instance, captured at the next rising edge.
   task automatic applyStimulus(input logic fv, input logic [7:0] f,
                                input logic av, input logic [7:0] a, input logic ack);
      freq_sample_valid = fv;
      freq_sample       = f;
      amp_sample_valid  = av;
      amp_sample        = a;
      done_ack          = ack;
      tick();
      freq_sample_valid = 1'b0;
      amp_sample_valid  = 1'b0;
      done_ack          = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Four-sample window with the same pair on every cycle, then two edges to publish.
   task automatic fullWindow(input logic [7:0] f, input logic [7:0] a);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, f, 1'b1, a, 1'b0);
      tick();
      tick();
   endtask

   initial begin
      $display("[TB] start");
      tick();
      tick();
      rst = 1'b0;

      // Reset in the middle of a partly filled window
      applyStimulus(1'b1, 8'd50, 1'b1, 8'd50, 1'b0);
      applyStimulus(1'b1, 8'd50, 1'b1, 8'd50, 1'b0);
      rst = 1'b1;
      tick(); tick(); tick();
      rst = 1'b0;
      checkOutput("rst_sig_f", 32'(sig_frequency), 32'd0);
      checkOutput("rst_sig_a", 32'(sig_amplitude), 32'd0);
      checkOutput("rst_done_f", 32'(frequency_adc_done), 32'd0);
      checkOutput("rst_done_a", 32'(amplitude_adc_done), 32'd0);
      checkOutput("rst_overrun", 32'(overrun), 32'd0);

      // First publish: window 10..13 / 200x4, latency of two edges after the last sample
      applyStimulus(1'b1, 8'd10, 1'b1, 8'd200, 1'b0);
      applyStimulus(1'b1, 8'd11, 1'b1, 8'd200, 1'b0);
      applyStimulus(1'b1, 8'd12, 1'b1, 8'd200, 1'b0);
      applyStimulus(1'b1, 8'd13, 1'b1, 8'd200, 1'b0);
      checkOutput("lat_t_done", 32'(frequency_adc_done), 32'd0);
      tick();
      checkOutput("lat_t1_done", 32'(frequency_adc_done), 32'd0);
      tick();
      checkOutput("pub1_done_f", 32'(frequency_adc_done), 32'd1);
      checkOutput("pub1_done_a", 32'(amplitude_adc_done), 32'd1);
      checkOutput("pub1_sig_f", 32'(sig_frequency), 32'd11);
      checkOutput("pub1_sig_a", 32'(sig_amplitude), 32'd200);
      checkOutput("pub1_overrun", 32'(overrun), 32'd0);
      applyStimulus(1'b0, 8'd0, 1'b0, 8'd0, 1'b1);
      checkOutput("ack1_done", 32'(frequency_adc_done), 32'd0);

      // Hysteresis: one-LSB moves on both channels are rejected, a 3-LSB move publishes
      fullWindow(8'd12, 8'd201);
      checkOutput("hyst_done", 32'(frequency_adc_done), 32'd0);
      checkOutput("hyst_sig_f", 32'(sig_frequency), 32'd11);
      checkOutput("hyst_sig_a", 32'(sig_amplitude), 32'd200);
      fullWindow(8'd14, 8'd201);
      checkOutput("pub2_done", 32'(amplitude_adc_done), 32'd1);
      checkOutput("pub2_sig_f", 32'(sig_frequency), 32'd14);
      checkOutput("pub2_sig_a", 32'(sig_amplitude), 32'd201);
      checkOutput("pub2_overrun", 32'(overrun), 32'd0);

      // Strobe during HOLD is dropped and flagged, outputs frozen
      applyStimulus(1'b1, 8'd99, 1'b0, 8'd0, 1'b0);
      checkOutput("hold_overrun", 32'(overrun), 32'd1);
      checkOutput("hold_sig_f", 32'(sig_frequency), 32'd14);
      checkOutput("hold_done", 32'(frequency_adc_done), 32'd1);

      // Ack and a freq strobe in the same cycle: release, sample not accumulated
      applyStimulus(1'b1, 8'd77, 1'b0, 8'd0, 1'b1);
      checkOutput("race_done", 32'(frequency_adc_done), 32'd0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'd40, 1'b1, 8'd201, 1'b1);
      applyStimulus(1'b1, 8'd40, 1'b1, 8'd201, 1'b0);
      checkOutput("accum_ack_done", 32'(frequency_adc_done), 32'd0);
      tick();
      tick();
      checkOutput("race_pub_done", 32'(frequency_adc_done), 32'd1);
      checkOutput("race_sig_f", 32'(sig_frequency), 32'd40);
      checkOutput("race_sig_a", 32'(sig_amplitude), 32'd201);

      // Reset while in HOLD; a window equal to the reset outputs still publishes
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("rst2_sig_f", 32'(sig_frequency), 32'd0);
      checkOutput("rst2_done", 32'(amplitude_adc_done), 32'd0);
      checkOutput("rst2_overrun", 32'(overrun), 32'd0);
      fullWindow(8'd0, 8'd0);
      checkOutput("firstpub_done", 32'(frequency_adc_done), 32'd1);
      checkOutput("firstpub_sig_f", 32'(sig_frequency), 32'd0);
      applyStimulus(1'b0, 8'd0, 1'b0, 8'd0, 1'b1);

      // Five freq strobes before any amp: the fifth is dropped
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'd20, 1'b0, 8'd0, 1'b0);
      checkOutput("drop_pre_overrun", 32'(overrun), 32'd0);
      applyStimulus(1'b1, 8'd100, 1'b0, 8'd0, 1'b0);
      checkOutput("drop_overrun", 32'(overrun), 32'd1);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'd0, 1'b1, 8'd30, 1'b0);
      tick();
      tick();
      checkOutput("drop_done", 32'(frequency_adc_done), 32'd1);
      checkOutput("drop_sig_f", 32'(sig_frequency), 32'd20);
      checkOutput("drop_sig_a", 32'(sig_amplitude), 32'd30);
      applyStimulus(1'b0, 8'd0, 1'b0, 8'd0, 1'b1);

      // Downward one-LSB move rejected, amplitude-only two-LSB drop publishes
      fullWindow(8'd19, 8'd31);
      checkOutput("neg_hyst_done", 32'(frequency_adc_done), 32'd0);
      checkOutput("neg_hyst_sig_a", 32'(sig_amplitude), 32'd30);
      fullWindow(8'd20, 8'd28);
      checkOutput("amp_pub_done", 32'(amplitude_adc_done), 32'd1);
      checkOutput("amp_pub_sig_f", 32'(sig_frequency), 32'd20);
      checkOutput("amp_pub_sig_a", 32'(sig_amplitude), 32'd28);
      applyStimulus(1'b0, 8'd0, 1'b0, 8'd0, 1'b1);

      // Wide window: 64 full-scale samples must not wrap, then 64 zeros
      for (int i = 0; i < 64; i++) begin
         w_freq_valid = 1'b1; w_freq_sample = 8'd255;
         w_amp_valid  = 1'b1; w_amp_sample  = 8'd255;
         tick();
      end
      w_freq_valid = 1'b0;
      w_amp_valid  = 1'b0;
      tick();
      tick();
      checkOutput("wide_max_done", 32'(w_freq_done), 32'd1);
      checkOutput("wide_max_sig_f", 32'(w_sig_frequency), 32'd255);
      checkOutput("wide_max_sig_a", 32'(w_sig_amplitude), 32'd255);
      w_done_ack = 1'b1;
      tick();
      w_done_ack = 1'b0;
      for (int i = 0; i < 64; i++) begin
         w_freq_valid = 1'b1; w_freq_sample = 8'd0;
         w_amp_valid  = 1'b1; w_amp_sample  = 8'd0;
         tick();
      end
      w_freq_valid = 1'b0;
      w_amp_valid  = 1'b0;
      tick();
      tick();
      checkOutput("wide_zero_done", 32'(w_amp_done), 32'd1);
      checkOutput("wide_zero_sig_f", 32'(w_sig_frequency), 32'd0);
      checkOutput("wide_zero_sig_a", 32'(w_sig_amplitude), 32'd0);
      checkOutput("wide_overrun", 32'(w_overrun), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
